// File: rtl/bcd_scan_ctrl.sv
// Multiplexed 7-segment scan controller sharing one external BCD decoder.
// Frame-aligned value updates, anti-ghost blanking, leading-zero suppression.
module bcd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    lz_suppress,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    load_ack,
  output logic                    frame_done,
  output logic                    digit_err
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4*NUM_DIGITS;

  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] active_q, active_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          ack_q, ack_d;
  logic          fd_q, fd_d;
  logic          err_q, err_d;

  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] zero_up;
  logic                  run;
  logic                  lz_hit;
  logic                  show;
  logic                  bad;
  logic                  dark;
  logic                  last_cnt;
  logic                  last_idx;
  logic                  boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
    end
  end

  // zero_up[k]: every active nibble from k up to the top digit is zero
  always_comb begin
    zero_up = '0;
    run     = 1'b1;
    for (int k = NUM_DIGITS-1; k >= 0; k--) begin
      run        = run & (active_q[4*k +: 4] == 4'd0);
      zero_up[k] = run;
    end
  end

  always_comb begin
    nib    = '0;
    lz_hit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib    = active_q[4*k +: 4];
        lz_hit = zero_up[k];
      end
    end
  end

  assign last_cnt = (cnt_q == CW'(REFRESH_DIV-1));
  assign last_idx = (idx_q == IW'(NUM_DIGITS-1));
  assign boundary = enable & last_cnt & last_idx;
  assign show     = enable & (cnt_q >= CW'(BLANK_CYCLES));
  assign bad      = (nib > 4'd9);
  assign dark     = bad | (lz_suppress & (idx_q != '0) & lz_hit);

  always_comb begin
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    fd_d      = boundary;
    if (!enable) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (last_cnt) begin
      cnt_d = '0;
      idx_d = last_idx ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // a load on the boundary itself skips the shadow stage
    if (load && boundary) begin
      active_d  = bcd_in;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end else begin
      if (boundary && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end
      if (load) begin
        shadow_d  = bcd_in;
        pending_d = 1'b1;
      end
    end
    err_d = ack_d ? 1'b0 : (err_q | (show & bad));
  end

  always_comb begin
    dig_en     = '0;
    seg_out    = '0;
    bcd_out    = nib;
    load_ack   = ack_q;
    frame_done = fd_q;
    digit_err  = err_q;
    if (show) begin
      dig_en  = NUM_DIGITS'(1) << idx_q;
      seg_out = dark ? 7'd0 : seg_in;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl: frame-position reference model feeding a
// scoreboard queue, compared against the DUT on every falling edge.
module tb_bcd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        lz;
  logic        ld;
  logic [15:0] din;
  logic [3:0]  bcd_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  logic        load_ack;
  logic        frame_done;
  logic        digit_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic [3:0] bcd;
    logic       ack;
    logic       fd;
    logic       err;
  } exp_t;

  exp_t sb[$];

  int          m_pos;
  logic [15:0] m_act;
  logic [15:0] m_shd;
  logic        m_pend;
  logic        m_ack;
  logic        m_fd;
  logic        m_err;

  always #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0: return 7'h7E;
      4'd1: return 7'h30;
      4'd2: return 7'h6D;
      4'd3: return 7'h79;
      4'd4: return 7'h33;
      4'd5: return 7'h5B;
      4'd6: return 7'h5F;
      4'd7: return 7'h70;
      4'd8: return 7'h7F;
      4'd9: return 7'h7B;
      default: return 7'h01;
    endcase
  endfunction

  // external shared decoder
  assign seg_in = dec7(bcd_out);

  bcd_scan_ctrl #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(en),
    .lz_suppress(lz),
    .load(ld),
    .bcd_in(din),
    .bcd_out(bcd_out),
    .seg_in(seg_in),
    .seg_out(seg_out),
    .dig_en(dig_en),
    .load_ack(load_ack),
    .frame_done(frame_done),
    .digit_err(digit_err)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_act  = '0;
    m_shd  = '0;
    m_pend = 1'b0;
    m_ack  = 1'b0;
    m_fd   = 1'b0;
    m_err  = 1'b0;
  endtask

  // one clock: predict, push, sample, pop, compare, advance model
  task automatic step();
    exp_t       e;
    exp_t       g;
    int         d;
    int         c;
    logic [3:0] nib;
    logic       show;
    logic       dark;
    logic       bnd;
    logic       app;
    d    = m_pos / 8;
    c    = m_pos % 8;
    nib  = m_act[4*d +: 4];
    show = en && (c >= 2);
    dark = (nib > 4'd9) || (lz && d > 0 && (m_act >> (4*d)) == 16'h0);
    e.dig = show ? 4'(1 << d) : 4'h0;
    e.seg = (show && !dark) ? dec7(nib) : 7'h0;
    e.bcd = nib;
    e.ack = m_ack;
    e.fd  = m_fd;
    e.err = m_err;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    check("dig_en", 16'(dig_en), 16'(g.dig));
    check("seg_out", 16'(seg_out), 16'(g.seg));
    check("bcd_out", 16'(bcd_out), 16'(g.bcd));
    check("load_ack", 16'(load_ack), 16'(g.ack));
    check("frame_done", 16'(frame_done), 16'(g.fd));
    check("digit_err", 16'(digit_err), 16'(g.err));
    bnd = en && (m_pos == 31);
    app = 1'b0;
    if (ld && bnd) begin
      m_act  = din;
      m_pend = 1'b0;
      app    = 1'b1;
    end else begin
      if (bnd && m_pend) begin
        m_act  = m_shd;
        m_pend = 1'b0;
        app    = 1'b1;
      end
      if (ld) begin
        m_shd  = din;
        m_pend = 1'b1;
      end
    end
    m_err = app ? 1'b0 : (m_err || (show && nib > 4'd9));
    m_ack = app;
    m_fd  = bnd;
    m_pos = en ? (m_pos + 1) % 32 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    ld  = 1'b1;
    din = v;
    step();
    ld  = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 40; i++) begin
      if (m_pos == p) break;
      step();
    end
    check("wait_pos", 16'(m_pos), 16'(p));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    lz    = 1'b0;
    ld    = 1'b0;
    din   = '0;
    model_reset();
    @(posedge clk);
    #1;
    run(2);
    rst_n = 1'b1;
    en    = 1'b1;

    do_load(16'h1234);
    run(70);

    lz = 1'b1;
    do_load(16'h0050);
    run(70);
    do_load(16'h0000);
    run(70);

    lz = 1'b0;
    wait_pos(5);
    do_load(16'h1111);
    run(3);
    do_load(16'h2222);
    run(70);

    wait_pos(31);
    do_load(16'h9999);
    run(40);

    do_load(16'h00A5);
    run(70);
    do_load(16'h0005);
    run(70);

    lz = 1'b1;
    do_load(16'h0123);
    run(40);
    wait_pos(21);
    en = 1'b0;
    step();
    run(2);
    do_load(16'h0300);
    run(3);
    en = 1'b1;
    run(70);

    wait_pos(10);
    do_load(16'h4444);
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_dig_en", 16'(dig_en), 16'h0);
    check("rst_seg_out", 16'(seg_out), 16'h0);
    check("rst_bcd_out", 16'(bcd_out), 16'h0);
    check("rst_load_ack", 16'(load_ack), 16'h0);
    check("rst_frame_done", 16'(frame_done), 16'h0);
    check("rst_digit_err", 16'(digit_err), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
